// File: rtl/sc_datamem_bhw.sv
// Data memory for the load/store path: byte/half/word access, load extension,
// error flagging, valid/ready request and a fixed-latency response pulse.
module sc_datamem_bhw #(
  parameter int unsigned DEPTH   = 64,
  parameter int unsigned AW      = 6,
  parameter int unsigned LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  localparam logic [3:0] WAIT_LAST = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] pend_rdata_q, pend_rdata_d;
  logic        pend_err_q, pend_err_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

  logic [31:0] mem [DEPTH] = '{default: '0};

  logic [AW-1:0] idx;
  logic [1:0]    lane;
  logic [31:0]   rd_word;
  logic [31:0]   rd_shift;
  logic [31:0]   ld_data;
  logic [31:0]   st_word;
  logic          acc_err;
  logic          accept;
  logic          mem_we;

  assign idx      = req_addr[AW+1:2];
  assign lane     = req_addr[1:0];
  assign rd_word  = mem[idx];
  assign rd_shift = rd_word >> {lane, 3'b000};

  assign req_ready = (state_q == S_IDLE) && !rst;
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  assign accept = req_valid && req_ready;
  assign mem_we = accept && req_we && !acc_err;

  always_comb begin
    acc_err = 1'b0;
    case (req_size)
      2'b00:   acc_err = 1'b0;
      2'b01:   acc_err = req_addr[0];
      2'b10:   acc_err = |lane;
      default: acc_err = 1'b1;
    endcase
    if (|req_addr[31:AW+2]) acc_err = 1'b1;
  end

  // Loads report zero for stores and for any errored access.
  always_comb begin
    ld_data = '0;
    case (req_size)
      2'b00: ld_data = req_unsigned ? {24'd0, rd_shift[7:0]}
                                    : {{24{rd_shift[7]}}, rd_shift[7:0]};
      2'b01: ld_data = req_unsigned ? {16'd0, rd_shift[15:0]}
                                    : {{16{rd_shift[15]}}, rd_shift[15:0]};
      2'b10: ld_data = rd_word;
      default: ld_data = '0;
    endcase
    if (acc_err || req_we) ld_data = '0;
  end

  always_comb begin
    st_word = rd_word;
    case (req_size)
      2'b00: st_word[{lane, 3'b000} +: 8] = req_wdata[7:0];
      2'b01: begin
        if (req_addr[1]) st_word[31:16] = req_wdata[15:0];
        else             st_word[15:0]  = req_wdata[15:0];
      end
      2'b10:   st_word = req_wdata;
      default: st_word = rd_word;
    endcase
  end

  // With LATENCY=1 the response registers load straight from the decode,
  // because the pending copy is not yet valid on that edge.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pend_rdata_d = pend_rdata_q;
    pend_err_d   = pend_err_q;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_err_d    = rsp_err_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          pend_rdata_d = ld_data;
          pend_err_d   = acc_err;
          cnt_d        = '0;
          if (LATENCY > 1) begin
            state_d = S_WAIT;
          end else begin
            state_d     = S_RESP;
            rsp_rdata_d = ld_data;
            rsp_err_d   = acc_err;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          state_d     = S_RESP;
          cnt_d       = '0;
          rsp_rdata_d = pend_rdata_q;
          rsp_err_d   = pend_err_q;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      pend_rdata_q <= '0;
      pend_err_q   <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pend_rdata_q <= pend_rdata_d;
      pend_err_q   <= pend_err_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  // RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[idx] <= st_word;
  end

endmodule

// File: tb/tb_sc_datamem_bhw.sv
// Scoreboard bench for sc_datamem_bhw: one LATENCY=1 and one LATENCY=3 instance
// driven by directed and random requests, checked against a byte-array model.
module tb_sc_datamem_bhw;

  localparam int unsigned DEPTH = 64;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int unsigned due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst          [2];
  logic        req_valid    [2];
  logic        req_ready    [2];
  logic        req_we       [2];
  logic [1:0]  req_size     [2];
  logic        req_unsigned [2];
  logic [31:0] req_addr     [2];
  logic [31:0] req_wdata    [2];
  logic        rsp_valid    [2];
  logic [31:0] rsp_rdata    [2];
  logic        rsp_err      [2];

  int unsigned cyc = 0;
  int          errors = 0;
  int          checks = 0;
  exp_t        q0[$];
  exp_t        q1[$];
  logic [7:0]  mdl [2][256];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sc_datamem_bhw #(.DEPTH(DEPTH), .AW(6), .LATENCY(1)) u_dut_l1 (
    .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_size(req_size[0]), .req_unsigned(req_unsigned[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  sc_datamem_bhw #(.DEPTH(DEPTH), .AW(6), .LATENCY(3)) u_dut_l3 (
    .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_size(req_size[1]), .req_unsigned(req_unsigned[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  function automatic int unsigned lat(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  // Byte-addressed little-endian reference memory.
  function automatic void model(input int k, input bit we, input logic [1:0] size,
                                input bit uns, input logic [31:0] addr,
                                input logic [31:0] wdata,
                                output logic [31:0] rd, output bit err);
    int unsigned n;
    logic [31:0] v;
    n   = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    err = (size == 2'd3) || ((addr % n) != 0) || (addr >= 4 * DEPTH);
    rd  = '0;
    if (err) return;
    if (we) begin
      for (int unsigned b = 0; b < n; b++) mdl[k][addr[7:0] + 8'(b)] = wdata[8*b +: 8];
    end else begin
      v = '0;
      for (int unsigned b = 0; b < n; b++) v |= 32'(mdl[k][addr[7:0] + 8'(b)]) << (8 * b);
      if (!uns && n < 4 && v[8*n-1]) v |= ~((32'd1 << (8 * n)) - 32'd1);
      rd = v;
    end
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic check_rsp(input int k, input exp_t e);
    cmp($sformatf("rsp_rdata[%0d]", k), rsp_rdata[k], e.rdata);
    cmp($sformatf("rsp_err[%0d]", k), 32'(rsp_err[k]), 32'(e.err));
    cmp($sformatf("rsp_cycle[%0d]", k), cyc, e.due);
  endtask

  task automatic unexpected(input int k);
    checks++;
    errors++;
    $display("FAIL unexpected_rsp[%0d]: got rsp_valid=1 expected no response at cycle %0d", k, cyc);
  endtask

  always @(negedge clk) begin
    if (rsp_valid[0]) begin
      if (q0.size() == 0) unexpected(0);
      else check_rsp(0, q0.pop_front());
    end
  end

  always @(negedge clk) begin
    if (rsp_valid[1]) begin
      if (q1.size() == 0) unexpected(1);
      else check_rsp(1, q1.pop_front());
    end
  end

  task automatic issue(input int k, input bit we, input logic [1:0] size, input bit uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input bit use_c, input logic [31:0] c_rd, input bit c_err);
    exp_t e;
    logic [31:0] mrd;
    bit merr;
    bit acc;
    @(negedge clk);
    req_valid[k]    = 1'b1;
    req_we[k]       = we;
    req_size[k]     = size;
    req_unsigned[k] = uns;
    req_addr[k]     = addr;
    req_wdata[k]    = wdata;
    acc = 1'b0;
    for (int i = 0; i < 50; i++) begin
      acc = req_ready[k];
      @(posedge clk);
      if (acc) break;
      @(negedge clk);
    end
    #1;
    req_valid[k] = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout[%0d]: got req_ready=0 for 50 cycles expected 1", k);
      return;
    end
    model(k, we, size, uns, addr, wdata, mrd, merr);
    e.rdata = use_c ? c_rd : mrd;
    e.err   = use_c ? c_err : merr;
    e.due   = cyc + lat(k) - 1;
    if (k == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic drain(input int k);
    for (int i = 0; i < 20; i++) begin
      if (((k == 0) ? q0.size() : q1.size()) == 0) break;
      @(negedge clk);
    end
    cmp($sformatf("drain_pending[%0d]", k), (k == 0) ? q0.size() : q1.size(), 0);
  endtask

  task automatic check_reset_outputs(input int k);
    cmp($sformatf("rst_req_ready[%0d]", k), 32'(req_ready[k]), 0);
    cmp($sformatf("rst_rsp_valid[%0d]", k), 32'(rsp_valid[k]), 0);
    cmp($sformatf("rst_rsp_rdata[%0d]", k), rsp_rdata[k], 0);
    cmp($sformatf("rst_rsp_err[%0d]", k), 32'(rsp_err[k]), 0);
  endtask

  task automatic random_ops(input int k, input int n);
    bit we;
    logic [1:0] size;
    logic [31:0] addr;
    int unsigned r;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      we = 1'($urandom % 2);
      r = $urandom_range(0, 15);
      size = (r < 5) ? 2'd0 : (r < 10) ? 2'd1 : (r < 15) ? 2'd2 : 2'd3;
      addr = 32'($urandom_range(0, 4 * DEPTH - 1));
      if ($urandom_range(0, 3) != 0 && size != 2'd3) addr &= ~((32'd1 << size) - 32'd1);
      if ($urandom_range(0, 15) == 0) addr = $urandom | 32'h0000_0100;
      issue(k, we, size, 1'($urandom % 2), addr, $urandom, 1'b0, '0, 1'b0);
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1; req_valid[k] = 1'b0; req_we[k] = 1'b0; req_size[k] = 2'd0;
      req_unsigned[k] = 1'b0; req_addr[k] = '0; req_wdata[k] = '0;
      for (int a = 0; a < 256; a++) mdl[k][a] = 8'h00;
    end
    repeat (2) @(negedge clk);
    check_reset_outputs(0);
    check_reset_outputs(1);
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    #1;
    cmp("ready_after_release[0]", 32'(req_ready[0]), 1);
    cmp("ready_after_release[1]", 32'(req_ready[1]), 1);

    issue(0, 1, 2'd2, 0, 32'h50, 32'hDEAD_BEEF, 1, 32'h0, 0);
    issue(0, 0, 2'd2, 0, 32'h50, 32'h0, 1, 32'hDEAD_BEEF, 0);
    issue(0, 1, 2'd0, 0, 32'h52, 32'h0000_0012, 1, 32'h0, 0);
    issue(0, 0, 2'd2, 0, 32'h50, 32'h0, 1, 32'hDE12_BEEF, 0);
    issue(0, 0, 2'd0, 0, 32'h53, 32'h0, 1, 32'hFFFF_FFDE, 0);
    issue(0, 0, 2'd0, 1, 32'h53, 32'h0, 1, 32'h0000_00DE, 0);
    issue(0, 0, 2'd1, 0, 32'h50, 32'h0, 1, 32'hFFFF_BEEF, 0);
    issue(0, 0, 2'd1, 1, 32'h52, 32'h0, 1, 32'h0000_DE12, 0);
    issue(0, 0, 2'd1, 0, 32'h51, 32'h0, 1, 32'h0, 1);
    issue(0, 1, 2'd2, 0, 32'h52, 32'h1122_3344, 1, 32'h0, 1);
    issue(0, 0, 2'd2, 0, 32'h50, 32'h0, 1, 32'hDE12_BEEF, 0);
    issue(0, 0, 2'd2, 0, 32'h100, 32'h0, 1, 32'h0, 1);
    issue(0, 0, 2'd3, 0, 32'h50, 32'h0, 1, 32'h0, 1);
    issue(0, 0, 2'd2, 0, 32'h50, 32'h0, 1, 32'hDE12_BEEF, 0);
    drain(0);

    // Reset with nonzero held response data; RAM must survive.
    @(negedge clk);
    rst[0] = 1'b1;
    @(negedge clk);
    check_reset_outputs(0);
    rst[0] = 1'b0;
    #1;
    cmp("ready_after_pulse[0]", 32'(req_ready[0]), 1);
    issue(0, 0, 2'd2, 0, 32'h50, 32'h0, 1, 32'hDE12_BEEF, 0);
    drain(0);

    // LATENCY=3: reset during WAIT drops the pending response.
    issue(1, 1, 2'd2, 0, 32'h40, 32'hCAFE_F00D, 1, 32'h0, 0);
    drain(1);
    issue(1, 0, 2'd2, 0, 32'h40, 32'h0, 1, 32'hCAFE_F00D, 0);
    @(posedge clk);
    @(negedge clk);
    rst[1] = 1'b1;
    q1.delete();
    @(negedge clk);
    check_reset_outputs(1);
    @(negedge clk);
    rst[1] = 1'b0;
    repeat (8) @(negedge clk);
    issue(1, 0, 2'd2, 0, 32'h40, 32'h0, 1, 32'hCAFE_F00D, 0);
    drain(1);

    random_ops(0, 200);
    drain(0);
    random_ops(1, 200);
    drain(1);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
